// File: rtl/alu_mult_seq_if.sv
// Shared ALU types and the ALU port bundle used by the sequential multiplier.
package alu_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL = 4'd0,
    ALU_SRL = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_NOR = 4'd7,
    ALU_SLT = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

// ALU port bundle: the ALU owns outport and flags, the initiator owns operands and op.
interface alu_if;
  import alu_pkg::*;

  word_t  portA;
  word_t  portB;
  word_t  outport;
  aluop_t aluop;
  logic   negative;
  logic   overflow;
  logic   zero;

  modport alu (input portA, portB, aluop, output outport, negative, overflow, zero);
  modport tb  (output portA, portB, aluop, input outport, negative, overflow, zero);
endinterface

// File: rtl/alu_mult_seq.sv
// Iterative shift-add unsigned multiplier. Borrows the datapath ALU adder for the
// accumulate step; keeps all shift/count state locally. Low 32 product bits plus a
// sticky flag that is set whenever the true product needs more than 32 bits.
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        ovf,
  alu_if.tb           aluif
);

  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(NBITS - 1);
  localparam logic [31:0] B_MASK = (NBITS >= 32) ? 32'hFFFF_FFFF
                                                 : ((32'd1 << NBITS) - 32'd1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   a_lat_q, a_lat_d;
  logic [31:0]   b_lat_q, b_lat_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   mcand_q, mcand_d;
  logic [31:0]   mplier_q, mplier_d;
  logic [CW-1:0] count_q, count_d;
  logic          sticky_q, sticky_d;
  logic [31:0]   product_q, product_d;
  logic          ovf_q, ovf_d;

  // Flags from the ALU carry no information for an unsigned add chain.
  logic unused_flags;
  assign unused_flags = aluif.negative ^ aluif.overflow ^ aluif.zero;

  // The ALU always computes acc + mcand; ITER decides whether to keep the sum.
  assign aluif.portA = acc_q;
  assign aluif.portB = mcand_q;
  assign aluif.aluop = ALU_ADD;

  assign busy    = (state_q == S_LOAD) || (state_q == S_ITER);
  assign done    = (state_q == S_DONE);
  assign product = product_q;
  assign ovf     = ovf_q;

  // Next-state and datapath update for the four-state multiply sequence.
  always_comb begin
    state_d   = state_q;
    a_lat_d   = a_lat_q;
    b_lat_d   = b_lat_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    sticky_d  = sticky_q;
    product_d = product_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts back-to-back requests just like IDLE.
        if (start) begin
          a_lat_d = op_a;
          b_lat_d = op_b & B_MASK;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        acc_d    = '0;
        mcand_d  = a_lat_q;
        mplier_d = b_lat_q;
        count_d  = '0;
        sticky_d = 1'b0;
        state_d  = S_ITER;
      end
      S_ITER: begin
        if ((EARLY_EXIT != 0) && (mplier_q == '0)) begin
          // Nothing left to add: finish without touching the working registers.
          state_d = S_DONE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = aluif.outport;
            // A wrapped sum is smaller than the addend it started from.
            if (aluif.outport < acc_q) begin
              sticky_d = 1'b1;
            end
          end
          // A set bit shifted out still has a multiplier bit above it to weigh it.
          if (mcand_q[31] && (mplier_q[31:1] != '0)) begin
            sticky_d = 1'b1;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            state_d = S_DONE;
          end
        end
        // Result registers change only as the operation completes.
        if (state_d == S_DONE) begin
          product_d = acc_d;
          ovf_d     = sticky_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      a_lat_q   <= '0;
      b_lat_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      sticky_q  <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_lat_q   <= a_lat_d;
      b_lat_q   <= b_lat_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      sticky_q  <= sticky_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: three instances (32-bit early exit, 32-bit full count,
// 8-bit early exit), each paired with a behavioural ALU adder.
module tb_alu_mult_seq;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start  [3];
  logic [31:0] opa    [3];
  logic [31:0] opb    [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic [31:0] prod_w [3];
  logic        ovf_w  [3];

  int tests_run;
  int tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    alu_if aluif ();
    assign aluif.outport  = (aluif.aluop == ALU_ADD) ? aluif.portA + aluif.portB : 32'h0;
    assign aluif.negative = aluif.outport[31];
    assign aluif.zero     = (aluif.outport == 32'h0);
    assign aluif.overflow = 1'b0;

    alu_mult_seq #(
      .NBITS      ((gi == 2) ? 8 : 32),
      .EARLY_EXIT ((gi == 1) ? 0 : 1)
    ) u_dut (
      .CLK     (clk),
      .nRST    (rst_n),
      .start   (start[gi]),
      .op_a    (opa[gi]),
      .op_b    (opb[gi]),
      .busy    (busy_w[gi]),
      .done    (done_w[gi]),
      .product (prod_w[gi]),
      .ovf     (ovf_w[gi]),
      .aluif   (aluif)
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: full-precision arithmetic on the masked multiplier, latency from bit position.
  function automatic void model(input int idx, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] p, output logic o, output int lat);
    int nbits;
    bit early;
    logic [31:0] mb;
    logic [63:0] full;
    int h;
    nbits = (idx == 2) ? 8 : 32;
    early = (idx != 1);
    mb = (nbits == 32) ? b : (b % (32'd1 << nbits));
    full = 64'(a) * 64'(mb);
    p = full[31:0];
    o = (full[63:32] != 0);
    h = -1;
    for (int i = 0; i < 32; i++) if (mb[i]) h = i;
    if (!early)              lat = nbits + 2;
    else if (h < 0)          lat = 3;
    else if (h == nbits - 1) lat = nbits + 2;
    else                     lat = h + 4;
  endfunction

  // Called just after a rising edge while in cycle n0; returns the cycle in which done is seen.
  task automatic wait_done(input int idx, input int n0, output int n, output bit seen);
    n = n0;
    seen = 0;
    while (!seen && n < 120) begin
      @(negedge clk);
      if (done_w[idx]) seen = 1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
  endtask

  // Called at a falling edge with the instance idle; ends at a falling edge in IDLE.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p, input logic exp_o, input int exp_lat,
                        input string tag);
    int n;
    bit seen;
    start[idx] = 1'b1;
    opa[idx] = a;
    opb[idx] = b;
    @(posedge clk);
    #1;
    start[idx] = 1'b0;
    wait_done(idx, 1, n, seen);
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " product"}, 64'(prod_w[idx]), 64'(exp_p));
    check({tag, " ovf"}, 64'(ovf_w[idx]), 64'(exp_o));
    @(negedge clk);
    check({tag, " done_width"}, 64'(done_w[idx]), 64'd0);
    $display("[TB] %s dut%0d %0h*%0h -> %0h ovf=%0d cycle=%0d", tag, idx, a, b,
             prod_w[idx], ovf_w[idx], n);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_p;
    logic        exp_o;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    bit seen;
    int dones;
    logic [31:0] ra, rb, mp;
    logic mo;
    int ml, ridx;

    vecs[0] = '{0, 32'd7,          32'd3,          32'd21,         1'b0, 5};
    vecs[1] = '{0, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1, 5};
    vecs[2] = '{0, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 4};
    vecs[3] = '{0, 32'h1234,       32'd0,          32'd0,          1'b0, 3};
    vecs[4] = '{1, 32'h1234,       32'd0,          32'd0,          1'b0, 34};
    vecs[5] = '{2, 32'd3,          32'd257,        32'd3,          1'b0, 4};
    vecs[6] = '{0, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 20};
    vecs[7] = '{1, 32'd7,          32'd3,          32'd21,         1'b0, 34};
    vecs[8] = '{0, 32'd1,          32'h8000_0000,  32'h8000_0000,  1'b0, 34};
    vecs[9] = '{2, 32'hFF,         32'hFF,         32'hFE01,       1'b0, 10};

    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      opa[i] = '0;
      opb[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy_w[0]), 64'd0);
    check("reset done", 64'(done_w[0]), 64'd0);
    check("reset product", 64'(prod_w[0]), 64'd0);
    check("reset ovf", 64'(ovf_w[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].exp_o,
             vecs[i].exp_lat, $sformatf("vec%0d", i));

    // Start while busy is ignored; start during DONE is accepted.
    start[0] = 1'b1; opa[0] = 32'd5; opb[0] = 32'd6;
    @(posedge clk); #1; start[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start[0] = 1'b1; opa[0] = 32'd9; opb[0] = 32'd9;
    @(posedge clk); #1; start[0] = 1'b0;
    wait_done(0, 4, n, seen);
    check("busy_start latency", 64'(n), 64'd6);
    check("busy_start product", 64'(prod_w[0]), 64'd30);
    $display("[TB] busy-start 5*6 -> %0d cycle=%0d", prod_w[0], n);
    start[0] = 1'b1; opa[0] = 32'd9; opb[0] = 32'd9;
    @(posedge clk); #1; start[0] = 1'b0;
    check("held product in LOAD", 64'(prod_w[0]), 64'd30);
    check("busy in LOAD", 64'(busy_w[0]), 64'd1);
    wait_done(0, 1, n, seen);
    check("done_start latency", 64'(n), 64'd7);
    check("done_start product", 64'(prod_w[0]), 64'd81);
    check("done_start ovf", 64'(ovf_w[0]), 64'd0);
    $display("[TB] done-start 9*9 -> %0d cycle=%0d", prod_w[0], n);
    @(negedge clk);

    // Asynchronous reset mid-ITER aborts the operation.
    run_op(0, 32'd11, 32'd13, 32'd143, 1'b0, 7, "pre_reset");
    start[0] = 1'b1; opa[0] = 32'd100; opb[0] = 32'd100;
    @(posedge clk); #1; start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy_w[0]), 64'd0);
    check("async rst done", 64'(done_w[0]), 64'd0);
    check("async rst product", 64'(prod_w[0]), 64'd0);
    check("async rst ovf", 64'(ovf_w[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_w[0]) dones++;
    end
    check("no done after abort", 64'(dones), 64'd0);
    $display("[TB] reset mid-op: done pulses after release=%0d", dones);
    run_op(0, 32'd12, 32'd12, 32'd144, 1'b0, 7, "post_reset");

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ridx = int'($urandom_range(0, 2));
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      model(ridx, ra, rb, mp, mo, ml);
      run_op(ridx, ra, rb, mp, mo, ml, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
